ppi_rw_control: RTL
===================

Name: ppi_rw_control

Overview:
- Read/write control and port-register stage directly downstream of the 8-bit data bus buffer in the PPI design.
- Decodes the host strobes (CS_n, A[1:0], WR_n, RD_n) and drives the buffer's internal write and read enables (IWR, IRD).
- Consumes the buffer's InternalBus to update port output latches and the control word, and returns read data for ports A, B and C.
- Only mode 0 (basic I/O) and port C bit set/reset are supported.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchronizer for each of CS_n, WR_n, RD_n and A[1:0]; minimum 2.
CTRL_RESET, 8'h9B, control-word value loaded at reset (all ports configured as inputs).

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset.
CS_n  input  1  chip select from host, active low, asynchronous.
A  input  2  host register address, asynchronous.
WR_n  input  1  host write strobe, active low, asynchronous.
RD_n  input  1  host read strobe, active low, asynchronous.
InternalBus  input  8  byte captured by the data bus buffer.
PA_in  input  8  port A pin inputs.
PB_in  input  8  port B pin inputs.
PC_in  input  8  port C pin inputs.
IWR  output  1  internal write enable to the buffer.
IRD  output  1  internal read enable to the buffer.
RdData  output  8  read data for the host read path.
PA_out  output  8  port A output latch.
PB_out  output  8  port B output latch.
PC_out  output  8  port C output latch.
PA_oe  output  1  port A output enable.
PB_oe  output  1  port B output enable.
PC_oe_hi  output  1  output enable for PC[7:4].
PC_oe_lo  output  1  output enable for PC[3:0].
CtrlWord  output  8  current control word.

Behaviour:
- Reset (RST=0, asynchronous): the FSM returns to IDLE and all synchronizers clear to the inactive value (1 for the strobes, 0 for A). Outputs take these values:
  - IWR=0, IRD=0, RdData=8'h00
  - PA_out=PB_out=PC_out=8'h00
  - CtrlWord=CTRL_RESET
  - all OE signals derived from CTRL_RESET: 0 for the default value.
- Reset mid-cycle aborts the cycle with no register update.
- Synchronization: cs_s, wr_s, rd_s and a_s are the outputs of a SYNC_STAGES-deep synchronizer. All decisions use only the synchronized signals.
- FSM states: IDLE, WRITE, COMMIT, READ.
  - IDLE, cs_s=0 and wr_s=0: go to WRITE, latch a_s into addr_q. Write has priority over read when both strobes are low.
  - IDLE, cs_s=0, rd_s=0 and wr_s=1: go to READ, latch a_s into addr_q.
  - WRITE: IWR=1. Stay while wr_s=0. When wr_s=1, go to COMMIT.
  - COMMIT (exactly one cycle): IWR=0. The InternalBus value is written to the target selected by addr_q on the edge leaving COMMIT, then the FSM returns to IDLE.
  - READ: IRD=1. Every cycle, RdData is registered from the source selected by addr_q. When rd_s=1, go to IDLE and clear IRD; RdData holds its last value.
- Once a cycle has started, CS_n and A changes are ignored until the strobe is released; the cycle still completes.
- A strobe held low after returning to IDLE does not start a new cycle. A new cycle requires the synchronized strobe to go high and then low again; this is tracked with a per-strobe armed flag.
- Write targets:
  - addr 00: PA_out
  - addr 01: PB_out
  - addr 10: PC_out
  - addr 11: control
- Control write with bit7=1 (mode set):
  - CtrlWord is loaded with the byte.
  - PA_out, PB_out and PC_out clear to 0.
  - Bits 6:5 and 2 are stored but ignored (mode 0 only).
  - PA_oe=~D4, PC_oe_hi=~D3, PB_oe=~D1, PC_oe_lo=~D0.
- Control write with bit7=0 (bit set/reset): PC_out[D3:D1] is set to D0. CtrlWord and the other bits are unchanged.
- Port latches are written regardless of direction. A latch only reaches the pins when its OE is 1.
- Read sources:
  - addr 00: PA_oe ? PA_out : PA_in
  - addr 01: PB_oe ? PB_out : PB_in
  - addr 10: per nibble, PC_oe_hi/PC_oe_lo select the latch or PC_in
  - addr 11: CtrlWord
- Latency: with SYNC_STAGES=2, a port latch updates on the 4th rising edge after the WR_n pad rises, measured from the edge that first samples the high level.

Test Plan:
- Reset release -> CtrlWord=8'h9B, all OE=0, PA_out/PB_out/PC_out=00, IWR=IRD=0, FSM in IDLE.
- Write 8'h80 to A=11, then 8'h5A to A=00 and 8'hC3 to A=01 -> all OE=1, PA_out=5A, PB_out=C3. IWR is high for the whole WRITE state and low in COMMIT.
- After mode 8'h80, write 8'h0F to A=11 (bit set/reset, sets PC7), then 8'h0A (clears PC5); start from PC_out=8'hFF, written via A=10 -> PC_out=8'hFF then 8'hDF, CtrlWord stays 8'h80.
- Mode 8'h98 (PA input, PC upper input, PB and PC lower output); PA_in=8'h3C, PC_in=8'hA5, PC_out=8'h0F; read A=00 and A=10 -> RdData=3C then AF, IRD high only in READ.
- WR_n and RD_n driven low together with CS_n=0, A=01, bus=8'h77 -> write cycle only, PB_out=77, IRD never asserts. Also change A mid-strobe -> the original address is used.
- Assert RST while in WRITE with bus=8'hEE, A=00 -> PA_out stays 00 and all outputs return to reset values immediately. WR_n held low through reset release does not start a cycle until it has gone high then low again.

Source files
------------

// File: rtl/ppi_rw_control_if.sv
// Host-side strobe/bus group between the PPI data bus buffer and the
// read/write control stage.
interface ppi_rw_control_if;
    logic       CS_n;
    logic [1:0] A;
    logic       WR_n;
    logic       RD_n;
    logic [7:0] InternalBus;
    logic       IWR;
    logic       IRD;
    logic [7:0] RdData;

    modport master (
        output CS_n, A, WR_n, RD_n, InternalBus,
        input  IWR, IRD, RdData
    );

    modport slave (
        input  CS_n, A, WR_n, RD_n, InternalBus,
        output IWR, IRD, RdData
    );
endinterface

// File: rtl/ppi_rw_control.sv
// PPI read/write control: synchronizes host strobes, sequences write/read
// cycles and holds the mode-0 port latches and control word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for an armed, chip-selected write or read strobe
// S_WRITE  | IWR high, waiting for the synchronized WR_n to rise
// S_COMMIT | single cycle; InternalBus is written to the addressed target
// S_READ   | IRD high, RdData refreshed every cycle until RD_n rises
module ppi_rw_control #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CTRL_RESET  = 8'h9B
) (
    input  logic        CLK,
    input  logic        RST,
    ppi_rw_control_if.slave bus,
    input  logic [7:0]  PA_in,
    input  logic [7:0]  PB_in,
    input  logic [7:0]  PC_in,
    output logic [7:0]  PA_out,
    output logic [7:0]  PB_out,
    output logic [7:0]  PC_out,
    output logic        PA_oe,
    output logic        PB_oe,
    output logic        PC_oe_hi,
    output logic        PC_oe_lo,
    output logic [7:0]  CtrlWord
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COMMIT, S_READ} state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0]      r_cs_sync, r_wr_sync, r_rd_sync, r_live;
    logic [SYNC_STAGES-1:0][1:0] r_a_sync;
    logic                        r_wr_armed, r_rd_armed;
    logic [1:0]                  r_addr;
    logic [7:0]                  r_rd_data;

    logic       w_cs_s, w_wr_s, w_rd_s, w_live;
    logic [1:0] w_a_s;
    logic       w_start_wr, w_start_rd;
    logic [7:0] w_rd_src;

    // r_live fills with ones once the chains hold real pad samples, so the
    // reset-forced high level on the strobes never counts as a release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cs_sync <= '1;
            r_wr_sync <= '1;
            r_rd_sync <= '1;
            r_a_sync  <= '0;
            r_live    <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], bus.CS_n};
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], bus.WR_n};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], bus.RD_n};
            r_a_sync  <= {r_a_sync[SYNC_STAGES-2:0], bus.A};
            r_live    <= {r_live[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_cs_s = r_cs_sync[SYNC_STAGES-1];
    assign w_wr_s = r_wr_sync[SYNC_STAGES-1];
    assign w_rd_s = r_rd_sync[SYNC_STAGES-1];
    assign w_a_s  = r_a_sync[SYNC_STAGES-1];
    assign w_live = r_live[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start_wr = 1'b0;
        w_start_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cs_s && !w_wr_s && r_wr_armed) begin
                    w_next     = S_WRITE;
                    w_start_wr = 1'b1;
                end else if (!w_cs_s && !w_rd_s && w_wr_s && r_rd_armed) begin
                    w_next     = S_READ;
                    w_start_rd = 1'b1;
                end
            end
            S_WRITE:  if (w_wr_s) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            S_READ:   if (w_rd_s) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // A strobe that is low when any cycle starts (including RD_n during a
    // write) must be released before it can start another cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
        end else begin
            if (w_live && w_wr_s)            r_wr_armed <= 1'b1;
            else if (w_start_wr || w_start_rd) r_wr_armed <= 1'b0;
            if (w_live && w_rd_s)            r_rd_armed <= 1'b1;
            else if (w_start_wr || w_start_rd) r_rd_armed <= 1'b0;
        end
    end

    always_comb begin
        w_rd_src = CtrlWord;
        case (r_addr)
            2'b00:   w_rd_src = PA_oe ? PA_out : PA_in;
            2'b01:   w_rd_src = PB_oe ? PB_out : PB_in;
            2'b10:   w_rd_src = {PC_oe_hi ? PC_out[7:4] : PC_in[7:4],
                                 PC_oe_lo ? PC_out[3:0] : PC_in[3:0]};
            default: w_rd_src = CtrlWord;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr    <= 2'b00;
            r_rd_data <= 8'h00;
            PA_out    <= 8'h00;
            PB_out    <= 8'h00;
            PC_out    <= 8'h00;
            CtrlWord  <= CTRL_RESET;
        end else begin
            if (w_start_wr || w_start_rd) r_addr <= w_a_s;
            if (r_state == S_READ) r_rd_data <= w_rd_src;
            if (r_state == S_COMMIT) begin
                case (r_addr)
                    2'b00: PA_out <= bus.InternalBus;
                    2'b01: PB_out <= bus.InternalBus;
                    2'b10: PC_out <= bus.InternalBus;
                    default: begin
                        if (bus.InternalBus[7]) begin
                            CtrlWord <= bus.InternalBus;
                            PA_out   <= 8'h00;
                            PB_out   <= 8'h00;
                            PC_out   <= 8'h00;
                        end else begin
                            PC_out[bus.InternalBus[3:1]] <= bus.InternalBus[0];
                        end
                    end
                endcase
            end
        end
    end

    assign PA_oe      = ~CtrlWord[4];
    assign PC_oe_hi   = ~CtrlWord[3];
    assign PB_oe      = ~CtrlWord[1];
    assign PC_oe_lo   = ~CtrlWord[0];

    assign bus.IWR    = (r_state == S_WRITE);
    assign bus.IRD    = (r_state == S_READ);
    assign bus.RdData = r_rd_data;

endmodule
